// File: rtl/instr_loader_if.sv
// instr_loader bus: byte stream handshake, instruction memory write port
// and load status, grouped for the loader and its environment.
interface instr_loader_if #(
  parameter int ADDR_W = 13
);
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output start,
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  core_rst,
    input  done,
    input  error,
    input  words_loaded
  );

  modport slave (
    input  start,
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output core_rst,
    output done,
    output error,
    output words_loaded
  );
endinterface

// File: rtl/instr_loader.sv
// Boot-time program loader: length-prefixed big-endian byte stream in,
// 32-bit instruction memory writes out, core held in reset until done.
module instr_loader #(
  parameter int ADDR_W    = 13,
  parameter int MAX_WORDS = 8192
) (
  input  logic         clk,
  input  logic         rst,
  instr_loader_if.slave bus
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic              core_q, core_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic [15:0]       len_cand;
  logic [31:0]       word_shift;
  logic [ADDR_W:0]   wl_inc;

  assign accept     = bus.byte_valid && ready_q;
  assign len_cand   = {len_q[15:8], bus.byte_in};
  assign word_shift = {word_q[23:0], bus.byte_in};
  assign wl_inc     = wl_q + 1'b1;

  // Next-state, datapath updates and registered-output targets.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    word_d  = word_q;
    wl_d    = wl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          state_d = S_LEN_HI;
          wl_d    = '0;
          idx_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {bus.byte_in, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = len_cand;
          if (len_cand == 16'd0 || len_cand > MAX_N) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = word_shift;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
            addr_d  = wl_q[ADDR_W-1:0];
            wdata_d = word_shift;
          end
        end
      end
      S_WRITE: begin
        wl_d = wl_inc;
        if (16'(wl_inc) == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_LEN_HI) ||
              (state_d == S_LEN_LO) ||
              (state_d == S_DATA);
    we_d    = (state_d == S_WRITE);
    core_d  = (state_d == S_DONE);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERROR);
  end

  // State and registered outputs; reset aborts any session in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      wl_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      core_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      wl_q    <= wl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      core_q  <= core_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.byte_ready   = ready_q;
  assign bus.mem_we       = we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.core_rst     = core_q;
  assign bus.done         = done_q;
  assign bus.error        = err_q;
  assign bus.words_loaded = wl_q;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: byte-count reference model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_instr_loader;
  localparam int AW   = 13;
  localparam int MAXW = 8192;

  logic clk = 1'b0;
  logic rst;

  instr_loader_if #(.ADDR_W(AW)) bus ();

  instr_loader #(
    .ADDR_W(AW),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state, expressed as byte/word counts of the session
  bit          m_act   = 1'b0;
  int          m_nb    = 0;
  int          m_n     = 0;
  logic [31:0] m_word  = '0;
  logic        m_ready = 1'b0;
  logic        m_we    = 1'b0;
  logic        m_core  = 1'b0;
  logic        m_done  = 1'b0;
  logic        m_err   = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  int          m_wl    = 0;
  int          cyc     = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_act = 0; m_nb = 0; m_n = 0; m_word = '0;
      m_ready = 0; m_we = 0; m_core = 0; m_done = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_wl = 0;
    end else if (m_we) begin
      m_we = 0;
      m_wl++;
      if (m_wl == m_n) begin
        m_act = 0; m_done = 1; m_core = 1;
      end else begin
        m_ready = 1;
      end
    end else if (m_act) begin
      if (bus.byte_valid && m_ready) begin
        m_nb++;
        if (m_nb == 1) begin
          m_n = int'(bus.byte_in) * 256;
        end else if (m_nb == 2) begin
          m_n = m_n + int'(bus.byte_in);
          if (m_n == 0 || m_n > MAXW) begin
            m_act = 0; m_err = 1; m_ready = 0;
          end
        end else begin
          m_word = {m_word[23:0], bus.byte_in};
          if ((m_nb - 2) % 4 == 0) begin
            m_we = 1; m_ready = 0;
            m_addr = AW'(m_wl);
            m_wdata = m_word;
          end
        end
      end
    end else if (bus.start) begin
      m_act = 1; m_nb = 0; m_wl = 0;
      m_done = 0; m_err = 0; m_core = 0; m_ready = 1;
    end
  end

  logic [31:0] mem [0:MAXW-1];
  int we_count  = 0;
  int last_addr = -1;
  int last_acc  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) begin
        mem[bus.mem_addr] = bus.mem_wdata;
        we_count++;
        last_addr = int'(bus.mem_addr);
      end
      chk("byte_ready", 64'(bus.byte_ready), 64'(m_ready));
      chk("mem_we", 64'(bus.mem_we), 64'(m_we));
      chk("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
      chk("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
      chk("core_rst", 64'(bus.core_rst), 64'(m_core));
      chk("done", 64'(bus.done), 64'(m_done));
      chk("error", 64'(bus.error), 64'(m_err));
      chk("words_loaded", 64'(bus.words_loaded), 64'(m_wl));
    end
  endtask

  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.byte_valid = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bit acc;
    t = 0;
    acc = 0;
    while (!acc && t < 2000) begin
      if (int'($urandom_range(99)) < gap) begin
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'($urandom);
      end else begin
        bus.byte_valid = 1'b1;
        bus.byte_in = b;
      end
      acc = bus.byte_valid && bus.byte_ready;
      @(negedge clk);
      t++;
    end
    last_acc = cyc;
    if (!acc) chk("send_byte_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic wait_end(input int bound);
    int t;
    t = 0;
    bus.byte_valid = 1'b0;
    while (!(bus.done || bus.error) && t < bound) begin
      @(negedge clk);
      t++;
    end
    chk("wait_end_timeout", 64'(bus.done || bus.error), 64'(1));
  endtask

  initial begin
    int t0;
    int wb;
    logic [31:0] w0, w1, wl;
    logic [31:0] ws [0:1];

    rst = 1'b0;
    bus.start = 1'b0;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    fork
      compare_loop();
    join_none

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_byte_ready", 64'(bus.byte_ready), 64'(0));
    chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
    chk("rst_core_rst", 64'(bus.core_rst), 64'(0));
    chk("rst_done_error", 64'({bus.done, bus.error}), 64'(0));
    chk("rst_words", 64'(bus.words_loaded), 64'(0));
    rst = 1'b1;
    idle(2);

    // basic load
    wb = we_count;
    pulse_start();
    send_byte(8'h00, 0);
    t0 = last_acc;
    send_byte(8'h02, 0);
    send_word(32'h12345678, 0);
    send_word(32'hDEADBEEF, 0);
    wait_end(40);
    chk("basic_latency", 64'(cyc - t0), 64'(11));
    chk("basic_mem0", 64'(mem[0]), 64'h12345678);
    chk("basic_mem1", 64'(mem[1]), 64'hDEADBEEF);
    chk("basic_writes", 64'(we_count - wb), 64'(2));
    chk("basic_words", 64'(bus.words_loaded), 64'(2));
    chk("basic_core_rst", 64'({bus.done, bus.core_rst}), 64'b11);

    // bad length headers
    wb = we_count;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_end(10);
    idle(2);
    chk("len0_error", 64'({bus.error, bus.core_rst, bus.byte_ready}), 64'b100);
    pulse_start();
    send_byte(8'h20, 0);
    send_byte(8'h01, 0);
    wait_end(10);
    idle(2);
    chk("len8193_error", 64'({bus.error, bus.core_rst, bus.byte_ready}), 64'b100);
    chk("badlen_writes", 64'(we_count - wb), 64'(0));

    // backpressure: bytes offered while not ready, random valid gaps
    bus.byte_in = 8'h5A;
    bus.byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    w0 = $urandom;
    pulse_start();
    send_byte(8'h00, 50);
    send_byte(8'h01, 50);
    send_word(w0, 50);
    wait_end(20);
    chk("bp_mem0", 64'(mem[0]), 64'(w0));
    chk("bp_done", 64'(bus.done), 64'(1));

    // reset mid-load after 6 data bytes of N=3
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_word($urandom, 0);
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 0);
    wb = we_count;
    bus.byte_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_words", 64'(bus.words_loaded), 64'(0));
    chk("mid_rst_outs", 64'({bus.byte_ready, bus.mem_we, bus.core_rst,
                             bus.done, bus.error}), 64'(0));
    chk("mid_rst_bus", 64'({bus.mem_addr, bus.mem_wdata}), 64'(0));
    bus.byte_in = 8'hA5;
    bus.byte_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_rst_nowrite", 64'(we_count - wb), 64'(0));
    ws[0] = $urandom;
    ws[1] = $urandom;
    pulse_start();
    send_byte(8'h00, 20);
    send_byte(8'h02, 20);
    send_word(ws[0], 20);
    send_word(ws[1], 20);
    wait_end(20);
    chk("fresh_mem0", 64'(mem[0]), 64'(ws[0]));
    chk("fresh_mem1", 64'(mem[1]), 64'(ws[1]));

    // restart after done, start in DATA ignored
    pulse_start();
    chk("restart_core_done", 64'({bus.core_rst, bus.done}), 64'b00);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hCA, 0);
    send_byte(8'hFE, 0);
    pulse_start();
    idle(2);
    send_byte(8'hF0, 0);
    send_byte(8'h0D, 0);
    wait_end(20);
    chk("restart_mem0", 64'(mem[0]), 64'hCAFEF00D);
    chk("restart_words", 64'(bus.words_loaded), 64'(1));
    chk("restart_done", 64'(bus.done), 64'(1));

    // boundary: N = 8192
    wb = we_count;
    w0 = $urandom;
    pulse_start();
    send_byte(8'h20, 0);
    send_byte(8'h00, 0);
    send_word(w0, 0);
    for (int i = 1; i < MAXW - 1; i++) send_word($urandom, 0);
    wl = $urandom;
    send_word(wl, 0);
    wait_end(20);
    idle(5);
    chk("bnd_last_addr", 64'(last_addr), 64'(MAXW - 1));
    chk("bnd_last_data", 64'(mem[MAXW-1]), 64'(wl));
    chk("bnd_first_data", 64'(mem[0]), 64'(w0));
    chk("bnd_writes", 64'(we_count - wb), 64'(MAXW));
    chk("bnd_words", 64'(bus.words_loaded), 64'(MAXW));
    chk("bnd_done", 64'(bus.done), 64'(1));
    w1 = 32'h0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
